// File: rtl/div_unit.sv
// div_unit: iterative restoring RV32M divide/remainder with a fixed WIDTH+1 cycle latency
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] quo, dvs, rem, rem_n, quo_n, a_abs, b_abs;
  logic [WIDTH:0] rem_s, diff;
  logic neg_q, neg_r, is_rem, sgn, ge, last;
  always_comb begin
    sgn   = ~op[0];
    a_abs = (sgn && srcA[WIDTH-1]) ? -srcA : srcA;
    b_abs = (sgn && srcB[WIDTH-1]) ? -srcB : srcB;
    rem_s = {rem, quo[WIDTH-1]};
    diff  = rem_s - {1'b0, dvs};
    ge    = rem_s >= {1'b0, dvs};
    rem_n = ge ? diff[WIDTH-1:0] : rem_s[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};
    last  = count == CW'(WIDTH - 1);
  end
  // The quotient sign fix is suppressed for a zero divisor so DIV x/0 stays all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            quo    <= a_abs;
            dvs    <= b_abs;
            rem    <= '0;
            count  <= '0;
            is_rem <= op[1];
            neg_q  <= sgn && (srcA[WIDTH-1] ^ srcB[WIDTH-1]) && (|srcB);
            neg_r  <= sgn && srcA[WIDTH-1];
          end
        end
        CALC: begin
          rem   <= rem_n;
          quo   <= quo_n;
          count <= count + 1'b1;
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            result <= is_rem ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
